// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with load formatting and a two-entry skid buffer.
// The writeback value is formatted when the instruction is accepted, so
// each held entry is already in its final form. The main register drives
// the outputs. The skid register catches one extra entry while WB stalls.
// in_ready and out_valid are registered. Both are derived from the next
// occupancy state.
module mem_wb_skid_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_result,
    input  logic                  in_Wreg,
    input  logic                  in_Rmem,
    input  logic [2:0]            in_funct3,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_wdata,
    output logic                  out_Wreg,
    output logic                  out_misalign
);

    // One held writeback entry, stored already formatted and qualified.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wdata;
        logic                  wreg;
        logic                  misalign;
    } entry_t;

    localparam int     ENTRY_W    = $bits(entry_t);
    localparam entry_t ENTRY_ZERO = entry_t'({ENTRY_W{1'b0}});

    // Occupancy of the two-entry buffer.
    // ST_ONE means only main is full. ST_TWO means main and skid are both full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    // Extracts the addressed byte/half and extends it; unknown codes act as LW.
    function automatic logic [XLEN-1:0] f_format_load(
        input logic [XLEN-1:0] rdata,
        input logic [1:0]      off,
        input logic [2:0]      funct3
    );
        logic [7:0]      v_byte;
        logic [15:0]     v_half;
        logic [XLEN-1:0] v_out;
        case (off)
            2'd0:    v_byte = rdata[7:0];
            2'd1:    v_byte = rdata[15:8];
            2'd2:    v_byte = rdata[23:16];
            default: v_byte = rdata[31:24];
        endcase
        if (off[1]) begin
            v_half = rdata[31:16];
        end else begin
            v_half = rdata[15:0];
        end
        case (funct3)
            3'b000:  v_out = {{(XLEN-8){v_byte[7]}}, v_byte};
            3'b100:  v_out = {{(XLEN-8){1'b0}}, v_byte};
            3'b001:  v_out = {{(XLEN-16){v_half[15]}}, v_half};
            3'b101:  v_out = {{(XLEN-16){1'b0}}, v_half};
            default: v_out = rdata;
        endcase
        return v_out;
    endfunction

    // Alignment rule per access size: bytes never misalign, halves need
    // off[0]=0, and words (including unknown codes) need off=0.
    function automatic logic f_load_misaligned(
        input logic [1:0] off,
        input logic [2:0] funct3
    );
        logic v_mis;
        case (funct3)
            3'b000,
            3'b100:  v_mis = 1'b0;
            3'b001,
            3'b101:  v_mis = off[0];
            default: v_mis = (off != 2'b00);
        endcase
        return v_mis;
    endfunction

    occ_t   r_state;
    entry_t r_main;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_in_ready;

    occ_t   w_state_next;
    entry_t w_main_next;
    entry_t w_skid_next;
    entry_t w_new;
    logic   w_pop;
    logic   w_accept;
    logic   w_misalign;
    logic   w_wreg_qual;

    // Format the incoming instruction into a complete entry.
    always_comb begin
        w_misalign  = in_Rmem & f_load_misaligned(in_result[1:0], in_funct3);
        w_wreg_qual = in_Wreg & (in_rd != {REG_ADDR_W{1'b0}}) & ~w_misalign;
        w_new.rd       = in_rd;
        w_new.wreg     = w_wreg_qual;
        w_new.misalign = w_misalign;
        if (in_Rmem) begin
            w_new.wdata = f_format_load(mem_rdata, in_result[1:0], in_funct3);
        end else begin
            w_new.wdata = in_result;
        end
    end

    // Next occupancy state and register contents. Flush overrides accept and pop.
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        w_pop        = r_out_valid & out_ready;
        w_accept     = in_valid & r_in_ready;
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_main_next  = ENTRY_ZERO;
            w_skid_next  = ENTRY_ZERO;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ST_ONE;
                        w_main_next  = w_new;
                    end else begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_accept) begin
                        // The new entry takes main's place in the same cycle.
                        w_state_next = ST_ONE;
                        w_main_next  = w_new;
                    end else if (w_pop) begin
                        // Main empties. Clear it so that out_Wreg drops to 0.
                        w_state_next = ST_EMPTY;
                        w_main_next  = ENTRY_ZERO;
                    end else if (w_accept) begin
                        w_state_next = ST_TWO;
                        w_skid_next  = w_new;
                    end else begin
                        w_state_next = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so the only possible event is a pop.
                    if (w_pop) begin
                        w_state_next = ST_ONE;
                        w_main_next  = r_skid;
                        w_skid_next  = ENTRY_ZERO;
                    end else begin
                        w_state_next = ST_TWO;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                    w_main_next  = ENTRY_ZERO;
                    w_skid_next  = ENTRY_ZERO;
                end
            endcase
        end
    end

    // State, entry and handshake registers. Reset clears everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= ST_EMPTY;
            r_main      <= ENTRY_ZERO;
            r_skid      <= ENTRY_ZERO;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_main      <= w_main_next;
            r_skid      <= w_skid_next;
            r_out_valid <= (w_state_next != ST_EMPTY);
            r_in_ready  <= (w_state_next != ST_TWO);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_rd       = r_main.rd;
    assign out_wdata    = r_main.wdata;
    assign out_Wreg     = r_main.wreg;
    assign out_misalign = r_main.misalign;

endmodule
